// File: rtl/serializer_stream.sv
// Word-to-beat serializer with valid/ready on both sides and selectable slice order.
// Define SERIALIZER_STREAM_HOLD_EN to add a one-word holding register for gap-free streaming.
module serializer_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int BEATS     = DATA_WIDTH / OUT_WIDTH;
  localparam int CNTR_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTR_BITS-1:0] LAST_CNT = CNTR_BITS'(BEATS - 1);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || OUT_WIDTH > DATA_WIDTH || OUT_WIDTH < 1) begin : g_bad_cfg
    $error("serializer_stream: DATA_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [CNTR_BITS-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_sh;
  logic                  r_valid;
  logic                  r_last;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_ready;
`ifdef SERIALIZER_STREAM_HOLD_EN
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] w_nxt_hold;
  logic                  w_nxt_hold_full;
`endif

  state_t                w_nxt_state;
  logic [CNTR_BITS-1:0]  w_nxt_cnt;
  logic [DATA_WIDTH-1:0] w_nxt_sh;
  logic                  w_nxt_valid;
  logic                  w_nxt_ready;
  logic                  w_in_xfer;
  logic                  w_out_xfer;

  function automatic logic [OUT_WIDTH-1:0] slice_f(input logic [DATA_WIDTH-1:0] sh,
                                                   input logic [CNTR_BITS-1:0]  cnt);
    logic [CNTR_BITS-1:0] idx;
    idx = MSB_FIRST ? (LAST_CNT - cnt) : cnt;
    return sh[idx*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  assign w_in_xfer  = i_valid && r_ready;
  assign w_out_xfer = r_valid && i_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_sh    = r_sh;
`ifdef SERIALIZER_STREAM_HOLD_EN
    w_nxt_hold      = r_hold;
    w_nxt_hold_full = r_hold_full;
`endif
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_nxt_sh    = i_data;
          w_nxt_cnt   = '0;
          w_nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_xfer && r_last) begin
          w_nxt_cnt = '0;
`ifdef SERIALIZER_STREAM_HOLD_EN
          // Hand-over keeps SHIFT so the next word follows without an idle cycle.
          if (r_hold_full) begin
            w_nxt_sh        = r_hold;
            w_nxt_hold_full = 1'b0;
          end else if (w_in_xfer) begin
            w_nxt_sh = i_data;
          end else begin
            w_nxt_state = IDLE;
          end
`else
          w_nxt_state = IDLE;
`endif
        end else begin
          if (w_out_xfer) begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
`ifdef SERIALIZER_STREAM_HOLD_EN
          if (w_in_xfer) begin
            w_nxt_hold      = i_data;
            w_nxt_hold_full = 1'b1;
          end
`endif
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they align with r_sh/r_cnt.
  assign w_nxt_valid = (w_nxt_state == SHIFT);
`ifdef SERIALIZER_STREAM_HOLD_EN
  assign w_nxt_ready = !w_nxt_hold_full;
`else
  assign w_nxt_ready = (w_nxt_state == IDLE);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_ready <= 1'b1;
`ifdef SERIALIZER_STREAM_HOLD_EN
      r_hold      <= '0;
      r_hold_full <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_sh    <= w_nxt_sh;
      r_valid <= w_nxt_valid;
      r_last  <= w_nxt_valid && (w_nxt_cnt == LAST_CNT);
      r_data  <= w_nxt_valid ? slice_f(w_nxt_sh, w_nxt_cnt) : '0;
      r_ready <= w_nxt_ready;
`ifdef SERIALIZER_STREAM_HOLD_EN
      r_hold      <= w_nxt_hold;
      r_hold_full <= w_nxt_hold_full;
`endif
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = r_valid;

endmodule

// File: tb/tb_serializer_stream.sv
// Directed bench for serializer_stream: three parameter sets share clock and reset.
module tb_serializer_stream;

  logic clk;
  logic rst_n;

  // A: 8x1 LSB-first
  logic       a_valid, a_ready, a_ovalid, a_olast, a_iready, a_busy;
  logic [7:0] a_data;
  logic [0:0] a_odata;
  // B: 16x4 MSB-first
  logic       b_valid, b_ready, b_ovalid, b_olast, b_iready, b_busy;
  logic [15:0] b_data;
  logic [3:0] b_odata;
  // C: 8x2 LSB-first
  logic       c_valid, c_ready, c_ovalid, c_olast, c_iready, c_busy;
  logic [7:0] c_data;
  logic [1:0] c_odata;

  int checks = 0;
  int errors = 0;

  serializer_stream #(.DATA_WIDTH(8), .OUT_WIDTH(1), .MSB_FIRST(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_data(a_data), .o_ready(a_ready),
    .o_data(a_odata), .o_valid(a_ovalid), .o_last(a_olast), .i_ready(a_iready), .o_busy(a_busy));

  serializer_stream #(.DATA_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready),
    .o_data(b_odata), .o_valid(b_ovalid), .o_last(b_olast), .i_ready(b_iready), .o_busy(b_busy));

  serializer_stream #(.DATA_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .i_data(c_data), .o_ready(c_ready),
    .o_data(c_odata), .o_valid(c_ovalid), .o_last(c_olast), .i_ready(c_iready), .o_busy(c_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    logic [3:0] exp_b [4];
    logic [1:0] exp_c [4];
    logic       exp_v, exp_r, exp_l, exp_d;
    int         acc2;

    exp_b = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_c = '{2'd3, 2'd0, 2'd0, 2'd3};
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_iready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_iready = 1'b1;
    c_valid = 1'b0; c_data = '0; c_iready = 1'b1;
    repeat (2) tick();

    check("rst_a_ready", a_ready, 1);
    check("rst_a_valid", a_ovalid, 0);
    check("rst_a_last", a_olast, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_data", a_odata, 0);
    check("rst_b_ready", b_ready, 1);
    check("rst_c_valid", c_ovalid, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_a_valid", a_ovalid, 0);

    // 8'hA5, 1-bit LSB-first
    a_valid = 1'b1; a_data = 8'hA5;
    tick();
    a_valid = 1'b0;
    w0 = 8'hA5;
    check("a5_ready_busy", a_ready, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_valid%0d", i), a_ovalid, 1);
      check($sformatf("a5_busy%0d", i), a_busy, 1);
      check($sformatf("a5_data%0d", i), a_odata, w0[i]);
      check($sformatf("a5_last%0d", i), a_olast, (i == 7));
      tick();
    end
    check("a5_gap_valid", a_ovalid, 0);
    check("a5_gap_ready", a_ready, 1);
    check("a5_gap_last", a_olast, 0);

    // 16'h1234, 4-bit MSB-first
    b_valid = 1'b1; b_data = 16'h1234;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b1234_valid%0d", i), b_ovalid, 1);
      check($sformatf("b1234_data%0d", i), b_odata, exp_b[i]);
      check($sformatf("b1234_last%0d", i), b_olast, (i == 3));
      tick();
    end
    check("b1234_end_valid", b_ovalid, 0);

    // 8'hC3, 2-bit LSB-first, stalled during beat 1
    c_valid = 1'b1; c_data = 8'hC3;
    tick();
    c_valid = 1'b0;
    check("c3_beat0", c_odata, exp_c[0]);
    tick();
    c_iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c3_stall_data%0d", i), c_odata, 2'd0);
      check($sformatf("c3_stall_valid%0d", i), c_ovalid, 1);
      check($sformatf("c3_stall_last%0d", i), c_olast, 0);
      check($sformatf("c3_stall_cnt%0d", i), u_c.r_cnt, 1);
      tick();
    end
    c_iready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("c3_data%0d", i), c_odata, exp_c[i]);
      check($sformatf("c3_last%0d", i), c_olast, (i == 3));
      tick();
    end
    check("c3_end_valid", c_ovalid, 0);

    // reset during beat 3 of 8'hFF
    a_valid = 1'b1; a_data = 8'hFF;
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    check("ff_beat3_valid", a_ovalid, 1);
    check("ff_beat3_data", a_odata, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", a_ovalid, 0);
    check("midrst_data", a_odata, 0);
    check("midrst_busy", a_busy, 0);
    #2 rst_n = 1'b1;
    tick();
    check("after_rst_ready", a_ready, 1);
    check("after_rst_valid", a_ovalid, 0);
    a_valid = 1'b1; a_data = 8'h01;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w01_data%0d", i), a_odata, (i == 0));
      check($sformatf("w01_last%0d", i), a_olast, (i == 7));
      tick();
    end
    check("w01_end_valid", a_ovalid, 0);

    // back-to-back words 8'h0F, 8'hF0 with i_valid held
    w0 = 8'h0F;
    w1 = 8'hF0;
`ifdef SERIALIZER_STREAM_HOLD_EN
    acc2 = 1;
`else
    acc2 = 9;
`endif
    a_valid = 1'b1; a_data = w0;
    tick();
    for (int e = 0; e < 18; e++) begin
      a_data  = w1;
      a_valid = (e < acc2);
`ifdef SERIALIZER_STREAM_HOLD_EN
      exp_v = (e < 16);
      exp_d = exp_v ? ((e < 8) ? w0[e] : w1[e-8]) : 1'b0;
      exp_r = !(e >= 1 && e <= 7);
      exp_l = (e == 7 || e == 15);
`else
      exp_v = (e != 8) && (e < 17);
      exp_d = (e < 8) ? w0[e] : ((e >= 9 && e < 17) ? w1[e-9] : 1'b0);
      exp_r = !exp_v;
      exp_l = (e == 7 || e == 16);
`endif
      check($sformatf("b2b_valid%0d", e), a_ovalid, exp_v);
      check($sformatf("b2b_ready%0d", e), a_ready, exp_r);
      check($sformatf("b2b_last%0d", e), a_olast, exp_l);
      if (exp_v) check($sformatf("b2b_data%0d", e), a_odata, exp_d);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer_stream.md
# serializer_stream

Parametrised successor to the single-bit serializer. Accepts a DATA_WIDTH word over a valid/ready handshake and emits it as DATA_WIDTH/OUT_WIDTH beats of OUT_WIDTH bits each. Supports:
- LSB-first or MSB-first slice order.
- Downstream backpressure.
- An optional holding register for gap-free back-to-back words.

It sits between a parallel producer (register file, FIFO) and a narrow serial link or PHY-side shifter.

## Interface
- DATA_WIDTH, 8: input word width in bits; must be a multiple of OUT_WIDTH.
- OUT_WIDTH, 1: bits per output beat; 1 ≤ OUT_WIDTH ≤ DATA_WIDTH.
- MSB_FIRST, 0: slice order; 0 = least significant slice first, 1 = most significant slice first.
- Derived: BEATS = DATA_WIDTH/OUT_WIDTH; CNTR_BITS = max(1, $clog2(BEATS)).
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous reset, active low; assertion clears state immediately, deassertion is synchronous to i_clk upstream.
- i_valid  in  1  upstream word valid.
- i_data  in  DATA_WIDTH  upstream word.
- o_ready  out  1  block can accept a word this cycle.
- o_data  out  OUT_WIDTH  current beat.
- o_valid  out  1  o_data holds a valid beat.
- o_last  out  1  current beat is the final slice of the word.
- i_ready  in  1  downstream accepts the beat this cycle.
- o_busy  out  1  a word is loaded in the shifter (equals o_valid).

## Operation
- Input transfer: i_valid && o_ready at a rising edge. Output transfer: o_valid && i_ready at a rising edge.
- State machine has two states: IDLE and SHIFT.
- IDLE:
  - o_valid = 0.
  - An input transfer loads i_data into shift register sh, clears counter cnt to 0, and moves to SHIFT.
- SHIFT:
  - o_valid = 1.
  - LSB-first: o_data = sh[cnt*OUT_WIDTH +: OUT_WIDTH]. MSB-first: o_data = sh[(BEATS-1-cnt)*OUT_WIDTH +: OUT_WIDTH].
  - o_last = (cnt == BEATS-1).
  - An output transfer with !o_last increments cnt.
  - An output transfer with o_last clears cnt and goes to the next word (holding register, if present and full) or to IDLE.
  - With no output transfer, cnt, sh and o_data are held stable; o_valid never drops mid-word.
- cnt never exceeds BEATS-1; it wraps only via the o_last transfer.
- BEATS = 1 is legal: o_last is 1 whenever o_valid is 1.
- Without the holding register: o_ready = (state == IDLE). Inputs are ignored while in SHIFT.
- Elaboration fails ($error) if DATA_WIDTH % OUT_WIDTH != 0 or OUT_WIDTH > DATA_WIDTH.

## Timing
- Reset values: state IDLE, cnt 0, sh 0, holding register empty. Outputs: o_valid 0, o_last 0, o_busy 0, o_data 0, o_ready 1.
- Reset mid-word: the word is discarded, outputs take reset values asynchronously, and the partial word is never resumed.
- Latency: a word accepted at edge k presents beat 0 with o_valid = 1 in the cycle after edge k.
- Base throughput, i_ready held high: one word per BEATS+1 cycles. There is one idle cycle (o_valid = 0, o_ready = 1) after each o_last transfer.
- o_ready depends only on registered state; there is no combinational path from i_ready or i_valid to o_ready.
- Stall: with i_ready = 0, o_data, o_last and cnt are held for any number of cycles.

## Configuration
- Macro: SERIALIZER_STREAM_HOLD_EN.
- Defined: adds a one-entry holding register hold with flag hold_full.
  - o_ready = !hold_full.
  - In IDLE, an input loads directly into sh and hold stays empty.
  - In SHIFT, an input loads into hold.
  - On an o_last transfer with hold_full: hold moves into sh, cnt goes to 0, hold_full is cleared, and SHIFT is kept. o_valid stays 1, giving zero-gap words: BEATS cycles per word.
  - Same edge as an o_last transfer, with hold_full = 0 and an input transfer: the input loads straight into sh and SHIFT is kept.
- Undefined: no holding register; behaviour is the base behaviour above.
- Reset clears hold_full in both builds.

## Test plan
- Reset, DATA_WIDTH=8, OUT_WIDTH=1, MSB_FIRST=0, i_ready=1: load 8'hA5 → o_data sequence 1,0,1,0,0,1,0,1. o_last is high only on beat 7, then o_valid = 0 for one cycle.
- DATA_WIDTH=16, OUT_WIDTH=4, MSB_FIRST=1: load 16'h1234 → beats 1,2,3,4 on consecutive cycles, o_last on the beat carrying 4.
- Backpressure: 8'hC3 with OUT_WIDTH=2, LSB-first, i_ready low for 3 cycles during beat 1 → o_data = 2'b00 held for all 3 cycles, cnt = 1 held, final sequence 3,0,0,3.
- Reset mid-word: assert i_rst_n = 0 during beat 3 of 8'hFF → o_valid and o_data go to 0 immediately. After release, o_ready = 1 and the next word 8'h01 starts at beat 0.
- HOLD_EN, i_valid held high with words 8'h0F then 8'hF0, OUT_WIDTH=1 → 16 consecutive valid beats with no gap. o_ready drops while hold is full and returns to 1 the cycle after the hand-over.
- Without HOLD_EN, same stimulus → the second word is accepted only in the idle cycle after the first o_last, giving 17 cycles total.
